// File: rtl/sonic_responder.sv
// Ultrasonic ranging sensor emulator: answers a validated trigger pulse with an
// echo pulse whose width encodes a target distance, HC-SR04 style.
module sonic_responder #(
    parameter int TICK_DIV    = 100,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 200,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [7:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       out_of_range,
    output logic       trig_short,
    output logic       trig_ignored
);

    localparam int CW = 16;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX    = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE    = PW'(1);
    localparam logic [CW-1:0] ONE          = CW'(1);
    localparam logic [CW-1:0] TRIG_MIN     = CW'(TRIG_MIN_US);
    localparam logic [CW-1:0] BURST_LAST   = CW'(BURST_US - 1);
    localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_US - 1);
    localparam logic [CW-1:0] TIMEOUT_W    = CW'(TIMEOUT_US);
    localparam logic [CW-1:0] CM_MAX       = CW'(MAX_CM);
    localparam logic [CW-1:0] US_CM        = CW'(US_PER_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t          state_q, state_d;
    logic            trig_meta_q, trig_meta_d;
    logic            trig_s_q, trig_s_d;
    logic            trig_prev_q, trig_prev_d;
    logic [1:0]      sync_vld_q, sync_vld_d;
    logic            armed_q, armed_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   us_cnt_q, us_cnt_d;
    logic [CW-1:0]   width_us_q, width_us_d;
    logic            out_of_range_q, out_of_range_d;
    logic            echo_q, echo_d;
    logic            trig_short_q, trig_short_d;
    logic            trig_ignored_q, trig_ignored_d;

    logic            tick;
    logic            trig_rise;
    logic            trig_fall;
    logic            in_range;
    logic [CW-1:0]   cm_wide;
    logic [CW-1:0]   width_now;

    // A trig already high when reset is released must not look like a rising
    // edge, so rises only count once trig_s has been seen low with valid data.
    assign tick      = (presc_q == PRESC_MAX);
    assign trig_rise = trig_s_q & ~trig_prev_q & armed_q;
    assign trig_fall = ~trig_s_q & trig_prev_q;
    assign cm_wide   = CW'(distance_cm);
    assign in_range  = (cm_wide != '0) && (cm_wide <= CM_MAX);
    assign width_now = (tick && (us_cnt_q < TRIG_MIN)) ? (us_cnt_q + ONE) : us_cnt_q;

    always_comb begin
        trig_meta_d = trig;
        trig_s_d    = trig_meta_q;
        trig_prev_d = trig_s_q;
        sync_vld_d  = {sync_vld_q[0], 1'b1};
        armed_d     = armed_q | (sync_vld_q[1] & ~trig_s_q);
    end

    always_comb begin
        state_d        = state_q;
        us_cnt_d       = tick ? (us_cnt_q + ONE) : us_cnt_q;
        presc_d        = tick ? '0 : (presc_q + PRESC_ONE);
        width_us_d     = width_us_q;
        out_of_range_d = out_of_range_q;
        trig_short_d   = 1'b0;
        trig_ignored_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG_HI;
                end
            end
            TRIG_HI: begin
                us_cnt_d = width_now;
                if (trig_fall) begin
                    if (width_now >= TRIG_MIN) begin
                        width_us_d     = in_range ? (cm_wide * US_CM) : TIMEOUT_W;
                        out_of_range_d = ~in_range;
                        state_d        = BURST;
                    end else begin
                        trig_short_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            BURST: begin
                trig_ignored_d = trig_rise;
                if (tick && (us_cnt_q == BURST_LAST)) begin
                    state_d = ECHO;
                end
            end
            ECHO: begin
                trig_ignored_d = trig_rise;
                if (tick && (us_cnt_q == (width_us_q - ONE))) begin
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                trig_ignored_d = trig_rise;
                if (tick && (us_cnt_q == HOLDOFF_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state entry restarts the time base so intervals are exact.
        if (state_d != state_q) begin
            presc_d  = '0;
            us_cnt_d = '0;
        end

        echo_d = (state_d == ECHO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            trig_meta_q    <= 1'b0;
            trig_s_q       <= 1'b0;
            trig_prev_q    <= 1'b0;
            sync_vld_q     <= '0;
            armed_q        <= 1'b0;
            presc_q        <= '0;
            us_cnt_q       <= '0;
            width_us_q     <= '0;
            out_of_range_q <= 1'b0;
            echo_q         <= 1'b0;
            trig_short_q   <= 1'b0;
            trig_ignored_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            trig_meta_q    <= trig_meta_d;
            trig_s_q       <= trig_s_d;
            trig_prev_q    <= trig_prev_d;
            sync_vld_q     <= sync_vld_d;
            armed_q        <= armed_d;
            presc_q        <= presc_d;
            us_cnt_q       <= us_cnt_d;
            width_us_q     <= width_us_d;
            out_of_range_q <= out_of_range_d;
            echo_q         <= echo_d;
            trig_short_q   <= trig_short_d;
            trig_ignored_q <= trig_ignored_d;
        end
    end

    assign echo         = echo_q;
    assign busy         = (state_q != IDLE) && (state_q != TRIG_HI);
    assign out_of_range = out_of_range_q;
    assign trig_short   = trig_short_q;
    assign trig_ignored = trig_ignored_q;

endmodule

// File: tb/tb_sonic_responder.sv
// Self-checking bench for sonic_responder: expected echo widths are queued when
// each trigger is driven and compared when the echo pulse is measured.
module tb_sonic_responder;

    localparam int TD          = 2;
    localparam int BURST_US    = 5;
    localparam int HOLDOFF_US  = 20;
    localparam int TIMEOUT_US  = 500;
    localparam int US_PER_CM   = 58;
    localparam int MAX_CM      = 200;
    // trig reaches trig_s two clocks after the raw pin changes
    localparam int SYNC_LAT    = 2;
    localparam int EXP_LAT     = SYNC_LAT + 1 + BURST_US * TD;
    localparam int EXP_TAIL    = HOLDOFF_US * TD;
    localparam int LIMIT       = 40000;

    typedef struct {
        int width;
        bit oor;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [7:0] distance_cm;
    logic       echo;
    logic       busy;
    logic       out_of_range;
    logic       trig_short;
    logic       trig_ignored;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   short_cnt = 0;
    int   ign_cnt = 0;
    int   echo_rises = 0;
    logic echo_prev = 1'b0;

    sonic_responder #(
        .TICK_DIV   (TD),
        .BURST_US   (BURST_US),
        .HOLDOFF_US (HOLDOFF_US),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig         (trig),
        .distance_cm  (distance_cm),
        .echo         (echo),
        .busy         (busy),
        .out_of_range (out_of_range),
        .trig_short   (trig_short),
        .trig_ignored (trig_ignored)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trig_short === 1'b1) short_cnt++;
        if (trig_ignored === 1'b1) ign_cnt++;
        if (echo === 1'b1 && echo_prev !== 1'b1) echo_rises++;
        echo_prev = echo;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t model(input int cm);
        exp_t e;
        if (cm >= 1 && cm <= MAX_CM) begin
            e.width = cm * US_PER_CM * TD;
            e.oor   = 1'b0;
        end else begin
            e.width = TIMEOUT_US * TD;
            e.oor   = 1'b1;
        end
        return e;
    endfunction

    task automatic push_expected(input int cm);
        sb.push_back(model(cm));
    endtask

    task automatic pulse_trig(input int us);
        trig = 1'b1;
        repeat (us * TD) @(negedge clk);
        trig = 1'b0;
    endtask

    // Starts right after trig is dropped; late_cm is applied once the distance
    // has been latched, so it must not influence the pulse being measured.
    task automatic capture_echo(input logic [7:0] late_cm, output int lat,
                                output int width, output int tail);
        lat = 0;
        width = 0;
        tail = 0;
        while (echo !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
            if (lat == 6) distance_cm = late_cm;
        end
        while (echo === 1'b1 && width < LIMIT) begin
            width++;
            @(negedge clk);
        end
        while (busy === 1'b1 && tail < LIMIT) begin
            tail++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        trig = 1'b0;
        distance_cm = 8'd0;
        repeat (3) @(negedge clk);
        total++; if (echo !== 1'b0) begin bad++; $display("[TB] FAIL reset_echo: got %b expected 0", echo); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        total++; if (out_of_range !== 1'b0) begin bad++; $display("[TB] FAIL reset_oor: got %b expected 0", out_of_range); end
        total++; if (trig_short !== 1'b0) begin bad++; $display("[TB] FAIL reset_short: got %b expected 0", trig_short); end
        total++; if (trig_ignored !== 1'b0) begin bad++; $display("[TB] FAIL reset_ignored: got %b expected 0", trig_ignored); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_normal;
        int lat, width, tail, s0;
        exp_t e;
        s0 = short_cnt;
        distance_cm = 8'd10;
        push_expected(10);
        pulse_trig(12);
        capture_echo(8'd10, lat, width, tail);
        e = sb.pop_front();
        total++; if (lat !== EXP_LAT) begin bad++; $display("[TB] FAIL normal_latency: got %0d expected %0d", lat, EXP_LAT); end
        total++; if (width !== e.width) begin bad++; $display("[TB] FAIL normal_width: got %0d expected %0d", width, e.width); end
        total++; if (out_of_range !== e.oor) begin bad++; $display("[TB] FAIL normal_oor: got %b expected %b", out_of_range, e.oor); end
        total++; if (tail !== EXP_TAIL) begin bad++; $display("[TB] FAIL normal_holdoff: got %0d expected %0d", tail, EXP_TAIL); end
        total++; if (short_cnt - s0 !== 0) begin bad++; $display("[TB] FAIL normal_no_short: got %0d expected 0", short_cnt - s0); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_range;
        int cms[3] = '{0, 201, 200};
        int lat, width, tail;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            distance_cm = 8'(cms[i]);
            push_expected(cms[i]);
            pulse_trig(12);
            capture_echo(8'd5, lat, width, tail);
            e = sb.pop_front();
            total++; if (width !== e.width) begin bad++; $display("[TB] FAIL range_width_cm%0d: got %0d expected %0d", cms[i], width, e.width); end
            total++; if (out_of_range !== e.oor) begin bad++; $display("[TB] FAIL range_oor_cm%0d: got %b expected %b", cms[i], out_of_range, e.oor); end
            total++; if (lat !== EXP_LAT) begin bad++; $display("[TB] FAIL range_latency_cm%0d: got %0d expected %0d", cms[i], lat, EXP_LAT); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_short;
        int lat, width, tail, s0, r0;
        exp_t e;
        s0 = short_cnt;
        r0 = echo_rises;
        distance_cm = 8'd250;
        pulse_trig(8);
        repeat (10) @(negedge clk);
        total++; if (short_cnt - s0 !== 1) begin bad++; $display("[TB] FAIL short_pulse_count: got %0d expected 1", short_cnt - s0); end
        total++; if (echo_rises - r0 !== 0) begin bad++; $display("[TB] FAIL short_no_echo: got %0d expected 0", echo_rises - r0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL short_idle: got %b expected 0", busy); end
        total++; if (out_of_range !== 1'b0) begin bad++; $display("[TB] FAIL short_oor_kept: got %b expected 0", out_of_range); end
        distance_cm = 8'd30;
        push_expected(30);
        pulse_trig(12);
        capture_echo(8'd30, lat, width, tail);
        e = sb.pop_front();
        total++; if (lat !== EXP_LAT) begin bad++; $display("[TB] FAIL short_follow_latency: got %0d expected %0d", lat, EXP_LAT); end
        total++; if (width !== e.width) begin bad++; $display("[TB] FAIL short_follow_width: got %0d expected %0d", width, e.width); end
        total++; if (out_of_range !== e.oor) begin bad++; $display("[TB] FAIL short_follow_oor: got %b expected %b", out_of_range, e.oor); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat, width, tail, n, i0, r0;
        exp_t e;
        i0 = ign_cnt;
        r0 = echo_rises;
        distance_cm = 8'd20;
        push_expected(20);
        pulse_trig(12);
        fork
            capture_echo(8'd20, lat, width, tail);
            begin
                n = 0;
                while (echo !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
                repeat (100) @(negedge clk);
                pulse_trig(12);
                n = 0;
                while (echo === 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
                repeat (4) @(negedge clk);
                pulse_trig(12);
            end
        join
        repeat (60) @(negedge clk);
        e = sb.pop_front();
        total++; if (ign_cnt - i0 !== 2) begin bad++; $display("[TB] FAIL b2b_ignored_count: got %0d expected 2", ign_cnt - i0); end
        total++; if (echo_rises - r0 !== 1) begin bad++; $display("[TB] FAIL b2b_echo_count: got %0d expected 1", echo_rises - r0); end
        total++; if (width !== e.width) begin bad++; $display("[TB] FAIL b2b_width: got %0d expected %0d", width, e.width); end
        total++; if (tail !== EXP_TAIL) begin bad++; $display("[TB] FAIL b2b_holdoff: got %0d expected %0d", tail, EXP_TAIL); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_echo;
        int lat, width, tail, n, r0;
        exp_t e;
        distance_cm = 8'd250;
        pulse_trig(12);
        n = 0;
        while (echo !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        repeat (TIMEOUT_US * TD / 2) @(negedge clk);
        total++; if (out_of_range !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_oor_before: got %b expected 1", out_of_range); end
        rst = 1'b1;
        #1;
        total++; if (echo !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_echo: got %b expected 0", echo); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        total++; if (out_of_range !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_oor: got %b expected 0", out_of_range); end
        total++; if ((trig_short | trig_ignored) !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_pulses: got %b expected 0", trig_short | trig_ignored); end
        trig = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r0 = echo_rises;
        repeat (50) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_busy: got %b expected 0", busy); end
        trig = 1'b0;
        repeat (100) @(negedge clk);
        total++; if (echo_rises - r0 !== 0) begin bad++; $display("[TB] FAIL rst_hold_no_echo: got %0d expected 0", echo_rises - r0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_idle: got %b expected 0", busy); end
        distance_cm = 8'd10;
        push_expected(10);
        pulse_trig(12);
        capture_echo(8'd10, lat, width, tail);
        e = sb.pop_front();
        total++; if (lat !== EXP_LAT) begin bad++; $display("[TB] FAIL rst_fresh_latency: got %0d expected %0d", lat, EXP_LAT); end
        total++; if (width !== e.width) begin bad++; $display("[TB] FAIL rst_fresh_width: got %0d expected %0d", width, e.width); end
        total++; if (out_of_range !== e.oor) begin bad++; $display("[TB] FAIL rst_fresh_oor: got %b expected %b", out_of_range, e.oor); end
    endtask

    initial begin
        rst = 1'b1;
        trig = 1'b0;
        distance_cm = 8'd0;
        test_reset();
        test_normal();
        test_range();
        test_short();
        test_back_to_back();
        test_reset_mid_echo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sonic_responder.md
SONIC_RESPONDER -- requirements
Module: sonic_responder

Interface
REQ-001 Parameter TICK_DIV, 100, clk cycles per 1 us time base (>=2).
REQ-002 Parameter TRIG_MIN_US, 10, minimum trig high width accepted as a valid trigger.
REQ-003 Parameter BURST_US, 200, delay from trig fall to echo rise (simulated 40 kHz burst).
REQ-004 Parameter US_PER_CM, 58, echo width per cm of target distance.
REQ-005 Parameter MAX_CM, 200, largest in-range distance.
REQ-006 Parameter TIMEOUT_US, 38000, echo width reported for no-target / out-of-range.
REQ-007 Parameter HOLDOFF_US, 10000, recovery time after echo fall before a new trigger is accepted.
REQ-008 clk  input  1  system clock.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 trig  input  1  asynchronous trigger from the ranging master.
REQ-011 distance_cm  input  8  target distance to report, unsigned cm.
REQ-012 echo  output  1  echo pulse, width encodes distance.
REQ-013 busy  output  1  high in every state except IDLE and TRIG_HI.
REQ-014 out_of_range  output  1  set at distance latch when the latched value is out of range, cleared at the next latch.
REQ-015 trig_short  output  1  one-cycle pulse when a trig pulse shorter than TRIG_MIN_US is rejected.
REQ-016 trig_ignored  output  1  one-cycle pulse on a trig rising edge seen while busy.

Function
REQ-017 trig is passed through a 2-flop synchronizer (trig_s); all edges are detected on trig_s against its previous value.
REQ-018 The us time base is a prescaler counting 0..TICK_DIV-1; it restarts at 0 on every state entry, so an N us interval lasts exactly N*TICK_DIV clk cycles.
REQ-019 The FSM has states IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
REQ-020 IDLE: a trig_s rising edge moves to TRIG_HI and clears the width counter; a trig_s level already high on IDLE entry does not count as a rising edge.
REQ-021 TRIG_HI: the width counter increments per us tick and saturates at TRIG_MIN_US.
REQ-022 TRIG_HI, trig_s falling with width >= TRIG_MIN_US: latch distance_cm, update out_of_range, move to BURST.
REQ-023 TRIG_HI, trig_s falling with width < TRIG_MIN_US: pulse trig_short, return to IDLE, leave out_of_range unchanged.
REQ-024 BURST lasts BURST_US us, then the FSM enters ECHO.
REQ-025 echo is registered and is high exactly while the state is ECHO.
REQ-026 ECHO width in us: latched_cm*US_PER_CM when 1 <= latched_cm <= MAX_CM; TIMEOUT_US otherwise (including latched_cm == 0).
REQ-027 Compute the echo width in us with at least 16 bits so that 255*58 and TIMEOUT_US do not overflow.
REQ-028 ECHO is followed by HOLDOFF, which lasts HOLDOFF_US us, then the FSM returns to IDLE.
REQ-029 Timing: if trig_s falls in cycle t, echo rises at t+1+BURST_US*TICK_DIV and stays high for exactly width_us*TICK_DIV cycles.
REQ-030 Any trig_s rising edge in BURST, ECHO or HOLDOFF pulses trig_ignored; the FSM is not disturbed.
REQ-031 distance_cm changes after the latch do not affect the measurement in progress.

Reset
REQ-032 While rst is high: state IDLE, echo 0, busy 0, out_of_range 0, trig_short 0, trig_ignored 0, synchronizer and all counters 0.
REQ-033 rst asserted mid-operation (including mid-echo) drops echo asynchronously; after rst is released, only a fresh trig rising edge starts a measurement.

Verification
(Bench parameters: TICK_DIV=2, BURST_US=5, HOLDOFF_US=20, TIMEOUT_US=500; all others default.)
REQ-034 distance_cm=10, trig high 12 us -> echo rises 11 clks after trig_s falls; echo high 1160 clks; out_of_range=0; busy drops 40 clks after echo falls.
REQ-035 distance_cm=0, then a separate run with 201, valid trig -> echo high 1000 clks and out_of_range=1 in both runs; a following run with distance_cm=200 -> 23200 clks, out_of_range=0.
REQ-036 trig high 8 us -> trig_short pulses once, echo stays 0, FSM returns to IDLE; an immediately following 12 us trig measures normally.
REQ-037 Second trig during ECHO and another during HOLDOFF -> trig_ignored pulses twice; echo width unchanged; no second echo.
REQ-038 rst pulsed halfway through echo -> echo low within the rst cycle; all outputs 0; trig held high across rst release -> no measurement until trig falls and rises again.
